// File: rtl/uart_stim_tx_pkg.sv
// Shared constants and FSM encoding for the UART stimulus transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_stim_tx_pkg;

  localparam int unsigned XTAL_FREQ_HZ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD = 115_200;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_START  = 3'd1,
    UART_TX_DATA   = 3'd2,
    UART_TX_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , UART_TX_PARITY = 3'd4
`endif
  } tx_state_e;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

endpackage

// File: rtl/uart_stim_tx_if.sv
// Byte-stream handshake into the UART stimulus transmitter.
interface uart_stim_tx_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/uart_stim_tx_fifo.sv
// Synchronous byte FIFO with show-ahead read data and async active-low reset.
module sync_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push_s, do_pop_s;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == {LW{1'b0}});
  assign level_o   = level_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_stim_tx.sv
// UART 8N1 transmitter fed from a byte FIFO; drives the core's rxd line.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 framing).
module uart_stim_tx
  import uart_stim_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = XTAL_FREQ_HZ,
  parameter int unsigned BAUD_RATE   = DEFAULT_BAUD,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  uart_stim_tx_if.slave                    in_if,
  output logic                             txd,
  output logic                             busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CW  = $clog2(DIV);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          pop_s, full_s, empty_s, last_s;
  logic [7:0]    head_s;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (in_if.valid_i),
    .wdata_i (in_if.data_i),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (fifo_level_o)
  );

  assign in_if.ready_o = ~full_s;
  assign txd           = txd_q;
  assign busy_o        = (state_q != UART_TX_IDLE) | (|fifo_level_o);
  assign last_s        = (cnt_q == CW'(DIV - 1));

  // txd_d always carries the level of the bit that starts at the next edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      UART_TX_IDLE: begin
        cnt_d = {CW{1'b0}};
        txd_d = 1'b1;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          state_d = UART_TX_START;
          txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(head_s);
`endif
        end else begin
          state_d = UART_TX_IDLE;
        end
      end
      UART_TX_START: begin
        if (last_s) begin
          cnt_d     = {CW{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = UART_TX_DATA;
          txd_d     = shift_q[0];
        end else begin
          state_d = UART_TX_START;
        end
      end
      UART_TX_DATA: begin
        if (last_s) begin
          cnt_d = {CW{1'b0}};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = UART_TX_PARITY;
            txd_d   = parity_q;
`else
            state_d = UART_TX_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          state_d = UART_TX_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      UART_TX_PARITY: begin
        if (last_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = UART_TX_STOP;
          txd_d   = 1'b1;
        end else begin
          state_d = UART_TX_PARITY;
        end
      end
`endif
      UART_TX_STOP: begin
        if (last_s) begin
          cnt_d = {CW{1'b0}};
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            state_d = UART_TX_START;
            txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(head_s);
`endif
          end else begin
            state_d = UART_TX_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          state_d = UART_TX_STOP;
        end
      end
      default: begin
        state_d = UART_TX_IDLE;
        cnt_d   = {CW{1'b0}};
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= UART_TX_IDLE;
      cnt_q     <= {CW{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed self-checking bench for uart_stim_tx at DIV = 50 MHz / 5 MBd = 10.
module tb_uart_stim_tx;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CYC = 11 * DIV;
`else
  localparam int FRAME_CYC = 10 * DIV;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txd;
  logic       busy;
  logic [3:0] level;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] burst_b [10];
  logic [7:0] rst_b [5];
  logic [7:0] ok_b [3];

  uart_stim_tx_if u_if ();

  uart_stim_tx #(
    .CLK_FREQ_HZ (50_000_000),
    .BAUD_RATE   (5_000_000),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .in_if        (u_if),
    .txd          (txd),
    .busy_o       (busy),
    .fifo_level_o (level)
  );

  always #5 clk = ~clk;

  // Entered #1 after the edge that drove the start bit low; checks txd every cycle.
  task automatic expect_frame(input logic [7:0] b);
    logic [10:0] bits;
    int nb;
    bits = {2'b01, b, 1'b0};
    nb   = 10;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
    nb   = 11;
`endif
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < DIV; c++) begin
        checks++;
        if (txd !== bits[k]) begin
          errors++;
          $display("FAIL frame_%02h bit %0d cyc %0d: txd=%b expected %b", b, k, c, txd, bits[k]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_if.valid_i = 1'b0;
    u_if.data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1)        begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    checks++; if (u_if.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", u_if.ready_o); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (level !== 4'd0)      begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: txd=%b busy=%b expected 1/0", txd, busy);
    end
  endtask

  task automatic test_single();
    @(negedge clk); u_if.data_i = 8'hA5; u_if.valid_i = 1'b1;
    @(posedge clk); #1; u_if.valid_i = 1'b0;
    checks++; if (txd !== 1'b1)   begin errors++; $display("FAIL single_txd_at_accept: got %b expected 1", txd); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level_at_accept: got %0d expected 1", level); end
    checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL single_busy_at_accept: got %b expected 1", busy); end
    @(posedge clk); #1;
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL single_level_after_pop: got %0d expected 0", level); end
    expect_frame(8'hA5);
    checks++; if (txd !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_end_idle: txd=%b busy=%b expected 1/0", txd, busy);
    end
  endtask

  task automatic test_burst();
    burst_b = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h7E, 8'h96};
    fork
      begin : push_thread
        int i = 0;
        int guard = 0;
        int stall = 0;
        logic acc;
        while (i < 10 && guard < 400) begin
          @(negedge clk);
          u_if.data_i  = burst_b[i];
          u_if.valid_i = 1'b1;
          acc = u_if.ready_o;
          @(posedge clk);
          guard++;
          if (acc) begin
            i++;
            if (i == 9) begin
              #1;
              checks++; if (u_if.ready_o !== 1'b0) begin errors++; $display("FAIL burst_ready_full: got %b expected 0", u_if.ready_o); end
              checks++; if (level !== 4'd8) begin errors++; $display("FAIL burst_level_full: got %0d expected 8", level); end
            end
          end else begin
            stall++;
          end
        end
        @(negedge clk); u_if.valid_i = 1'b0;
        checks++; if (i != 10) begin errors++; $display("FAIL burst_accept_timeout: accepted %0d expected 10", i); end
        checks++; if (stall != FRAME_CYC - 7) begin
          errors++; $display("FAIL burst_tenth_stall: stalled %0d cycles expected %0d", stall, FRAME_CYC - 7);
        end
      end
      begin : frame_thread
        int t = 0;
        while (txd !== 1'b0 && t < 50) begin
          @(posedge clk); #1; t++;
        end
        checks++;
        if (txd !== 1'b0) begin
          errors++; $display("FAIL burst_start_timeout: txd=%b expected 0", txd);
        end else begin
          for (int f = 0; f < 10; f++) expect_frame(burst_b[f]);
        end
      end
    join
    checks++; if (txd !== 1'b1 || busy !== 1'b0 || level !== 4'd0) begin
      errors++; $display("FAIL burst_end_idle: txd=%b busy=%b level=%0d expected 1/0/0", txd, busy, level);
    end
  endtask

  task automatic test_reset_midframe();
    int lows = 0;
    rst_b = '{8'h3C, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); u_if.data_i = rst_b[j]; u_if.valid_i = 1'b1;
      @(posedge clk);
    end
    #1; u_if.valid_i = 1'b0;
    checks++; if (level !== 4'd4) begin errors++; $display("FAIL midrst_level_before: got %0d expected 4", level); end
    // Start began one edge after the first accept; bit 3 occupies start+40..start+49.
    repeat (42) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL midrst_bit3: txd=%b expected 1", txd); end
    #2; rst_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1)          begin errors++; $display("FAIL midrst_txd: got %b expected 1", txd); end
    checks++; if (level !== 4'd0)        begin errors++; $display("FAIL midrst_level: got %0d expected 0", level); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (u_if.ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", u_if.ready_o); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL midrst_no_restart: %0d low cycles expected 0", lows); end
    checks++; if (level !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_stays_empty: level=%0d busy=%b expected 0/0", level, busy);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    @(negedge clk); u_if.data_i = 8'h07; u_if.valid_i = 1'b1;
    @(posedge clk); #1; u_if.valid_i = 1'b0;
    @(posedge clk); #1;
    repeat (9 * DIV) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL parity_07: txd=%b expected 1", txd); end
    repeat (2 * DIV) @(posedge clk);
    #1;
    @(negedge clk); u_if.data_i = 8'h03; u_if.valid_i = 1'b1;
    @(posedge clk); #1; u_if.valid_i = 1'b0;
    @(posedge clk); #1;
    expect_frame(8'h03);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parity_03_end: busy=%b expected 0", busy); end
  endtask
`endif

  task automatic test_loopback();
    logic [7:0] rx;
    int t;
    ok_b = '{8'h4F, 8'h4B, 8'h0A};
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); u_if.data_i = ok_b[j]; u_if.valid_i = 1'b1;
      @(posedge clk);
    end
    #1; u_if.valid_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      t = 0;
      while (txd !== 1'b0 && t < 200) begin
        @(posedge clk); #1; t++;
      end
      checks++;
      if (txd !== 1'b0) begin
        errors++; $display("FAIL loop_start_%0d: no start bit seen", j);
        break;
      end
      repeat (DIV / 2) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (DIV) @(posedge clk);
        #1; rx[k] = txd;
      end
`ifdef UART_TX_PARITY_EN
      repeat (DIV) @(posedge clk);
`endif
      repeat (DIV) @(posedge clk);
      #1;
      checks++; if (rx !== ok_b[j]) begin errors++; $display("FAIL loop_byte_%0d: got 0x%02h expected 0x%02h", j, rx, ok_b[j]); end
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL loop_stop_%0d: txd=%b expected 1", j, txd); end
    end
    repeat (FRAME_CYC) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_end_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
